if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_fetch_fifo.sv | 90 +++++++++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: datapath widths, reset defaults, buffer entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_pkg;

    localparam int CPU_WIDTH = 16;
    localparam int ADDR_W    = 16;

    localparam logic [CPU_WIDTH-1:0] NOP_INST_DEF  = 16'h0000;
    localparam logic [ADDR_W-1:0]    RESET_PC_DEF  = 16'h0000;
    localparam int                   MAX_OUTST_DEF = 2;

    // One fetched instruction together with the word address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [CPU_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO holding returned instruction words with their PCs.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: full_o; a push while full is only legal together with a pop.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = MAX_OUTST_DEF,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which the push then reuses.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; flush empties the queue regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents of free slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // The issue limit upstream is what keeps this from ever overflowing.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC generation, in-order imem requests, response buffering, IF/ID register.
// Latency: request cycle n, response n+1, instruction valid at decode in n+2; 1 instr/cycle sustained.
// Backpressure: stall_i holds IF/ID; requests stop once outstanding + buffered reaches MAX_OUTST.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0]    RESET_PC  = RESET_PC_DEF,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = NOP_INST_DEF,
    parameter int                   MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [ADDR_W-1:0]    redirect_pc_i,
    output logic [CPU_WIDTH-1:0] inst_o,
    output logic                 inst_valid_o,
    output logic [ADDR_W-1:0]    pc_o,
    output logic [ADDR_W-1:0]    pc_plus1_o
);

    localparam int            OW      = cnt_width(MAX_OUTST);
    localparam logic [OW:0]   LIMIT_C = (OW + 1)'(MAX_OUTST);

    // Fetch-side state.
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;

    // IF/ID register.
    fetch_entry_t      id_q, id_d;
    logic              valid_q, valid_d;

    // Buffer interface.
    fetch_entry_t      buf_head;
    fetch_entry_t      rsp_entry;
    logic              buf_push, buf_pop, buf_flush;
    logic              buf_full, buf_empty;
    logic [OW-1:0]     buf_count;

    logic [OW:0]       in_flight;
    logic              hs;
    logic              rsp;
    logic              accept;

    fetch_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (buf_push),
        .push_dat_i (rsp_entry),
        .pop_i      (buf_pop),
        .flush_i    (buf_flush),
        .head_o     (buf_head),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .count_o    (buf_count)
    );

    // Every granted request must have a slot waiting for its word, so issue is
    // limited by requests in flight plus words already buffered.
    assign in_flight = {1'b0, outst_q} + {1'b0, buf_count};
    assign imem_req  = rst_n & (in_flight < LIMIT_C);
    assign imem_addr = pc_q;
    assign hs        = imem_req & imem_gnt;

    // A response with nothing outstanding cannot belong to us and is ignored.
    assign rsp       = imem_rvalid & (outst_q != '0);
    // Words for pre-redirect requests, including one arriving in the redirect cycle, are dropped.
    assign accept    = rsp & (drop_q == '0) & ~redirect_i;
    assign rsp_entry = '{pc: resp_pc_q, inst: imem_rdata};

    // PC, response-PC, outstanding and drop counter next-state.
    always_comb begin
        outst_d   = outst_q + OW'(hs) - OW'(rsp);
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        drop_d    = drop_q;
        if (redirect_i) begin
            pc_d      = redirect_pc_i;
            resp_pc_d = redirect_pc_i;
            // Everything still in flight after this cycle was fetched down the old path.
            drop_d    = outst_d;
        end else begin
            if (hs) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (accept) begin
                resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
        end
    end

    // IF/ID update: redirect, then stall, then buffer head, then bypass, else bubble.
    always_comb begin
        id_d      = id_q;
        valid_d   = valid_q;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;
        if (redirect_i) begin
            id_d.inst = NOP_INST;
            valid_d   = 1'b0;
            buf_flush = 1'b1;
        end else if (stall_i) begin
            buf_push = accept;
        end else if (!buf_empty) begin
            id_d     = buf_head;
            valid_d  = 1'b1;
            buf_pop  = 1'b1;
            buf_push = accept;
        end else if (accept) begin
            id_d    = rsp_entry;
            valid_d = 1'b1;
        end else begin
            id_d.inst = NOP_INST;
            valid_d   = 1'b0;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q    <= '{pc: '0, inst: NOP_INST};
            valid_q <= 1'b0;
        end else begin
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o       = id_q.inst;
    assign inst_valid_o = valid_q;
    assign pc_o         = id_q.pc;
    assign pc_plus1_o   = id_q.pc + ADDR_W'(1);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic [15:0] pc_o;
    logic [15:0] pc_plus1_o;

    int errors = 0;
    int checks = 0;
    int mem_lat = 1;
    int cyc = 0;
    int q_addr[$];
    int q_due[$];

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .pc_o          (pc_o),
        .pc_plus1_o    (pc_plus1_o)
    );

    // Instruction memory: mem[a] = 16'h1000 + a, in-order responses mem_lat cycles after grant.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
                imem_rvalid = 1'b0;
            end else begin
                if (q_due.size() > 0 && q_due[0] <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 16'h1000 + 16'(q_addr[0]);
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = 16'hdead;
                end
                if (imem_req && imem_gnt) begin
                    q_addr.push_back(int'(imem_addr));
                    q_due.push_back(cyc + mem_lat);
                end
            end
        end
    end

    task automatic do_reset(input logic gnt, input int lat);
        @(negedge clk);
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0;
        imem_gnt = gnt; mem_lat = lat;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0;
        imem_gnt = 1'b1; mem_lat = 1;
        repeat (3) @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
        checks++; if (inst_o !== 16'h0000) begin errors++; $display("FAIL rst_inst: got %h want 0000", inst_o); end
        checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", pc_o); end
        checks++; if (pc_plus1_o !== 16'h0001) begin errors++; $display("FAIL rst_pc1: got %h want 0001", pc_plus1_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_stream;
        logic [15:0] e;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL str_req1: got req=%b addr=%h want 1/0001", imem_req, imem_addr); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL str_early: got valid=%b want 0", inst_valid_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = 16'h1000 + 16'(i);
            checks++; if (inst_valid_o !== 1'b1 || inst_o !== e) begin errors++; $display("FAIL str_inst%0d: got v=%b %h want 1/%h", i, inst_valid_o, inst_o, e); end
            checks++; if (pc_o !== 16'(i) || pc_plus1_o !== 16'(i + 1)) begin errors++; $display("FAIL str_pc%0d: got %h/%h want %h/%h", i, pc_o, pc_plus1_o, 16'(i), 16'(i + 1)); end
            checks++; if (imem_addr !== 16'(i + 2)) begin errors++; $display("FAIL str_addr%0d: got %h want %h", i, imem_addr, 16'(i + 2)); end
        end
    endtask

    task automatic test_stall;
        logic [15:0] e;
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1002 || pc_o !== 16'h0002) begin errors++; $display("FAIL stall_hold%0d: got v=%b %h pc=%h want 1/1002/0002", k, inst_valid_o, inst_o, pc_o); end
            if (k < 2) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %b want 0", k, imem_req); end
            end
        end
        stall_i = 1'b0;
        for (int i = 3; i < 7; i++) begin
            @(negedge clk);
            e = 16'h1000 + 16'(i);
            checks++; if (inst_valid_o !== 1'b1 || inst_o !== e || pc_o !== 16'(i)) begin errors++; $display("FAIL stall_resume%0d: got v=%b %h pc=%h want 1/%h/%h", i, inst_valid_o, inst_o, pc_o, e, 16'(i)); end
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b1, 2);
        repeat (3) @(negedge clk);
        checks++; if (inst_o !== 16'h1000 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL rd_pre0: got v=%b %h want 1/1000", inst_valid_o, inst_o); end
        @(negedge clk);
        checks++; if (inst_o !== 16'h1001 || pc_o !== 16'h0001) begin errors++; $display("FAIL rd_pre1: got %h pc=%h want 1001/0001", inst_o, pc_o); end
        redirect_i = 1'b1; redirect_pc_i = 16'h0040;
        @(negedge clk);
        redirect_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 16'h0000) begin errors++; $display("FAIL rd_nop: got v=%b %h want 0/0000", inst_valid_o, inst_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_full: got %b want 0", imem_req); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rd_drop0: got v=%b %h want 0", inst_valid_o, inst_o); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL rd_addr: got req=%b %h want 1/0040", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rd_drop1: got v=%b %h want 0", inst_valid_o, inst_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rd_bubble: got v=%b %h want 0", inst_valid_o, inst_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1040) begin errors++; $display("FAIL rd_first: got v=%b %h want 1/1040", inst_valid_o, inst_o); end
        checks++; if (pc_o !== 16'h0040 || pc_plus1_o !== 16'h0041) begin errors++; $display("FAIL rd_first_pc: got %h/%h want 0040/0041", pc_o, pc_plus1_o); end
        @(negedge clk);
        checks++; if (inst_o !== 16'h1041 || pc_o !== 16'h0041) begin errors++; $display("FAIL rd_second: got %h pc=%h want 1041/0041", inst_o, pc_o); end
    endtask

    task automatic test_redirect_stall;
        do_reset(1'b1, 1);
        repeat (3) @(negedge clk);
        checks++; if (inst_o !== 16'h1001) begin errors++; $display("FAIL rs_pre: got %h want 1001", inst_o); end
        stall_i = 1'b1;
        @(negedge clk);
        checks++; if (inst_o !== 16'h1001 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL rs_hold: got v=%b %h want 1/1001", inst_valid_o, inst_o); end
        redirect_i = 1'b1; redirect_pc_i = 16'h0080;
        @(negedge clk);
        redirect_i = 1'b0; stall_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 16'h0000) begin errors++; $display("FAIL rs_nop: got v=%b %h want 0/0000", inst_valid_o, inst_o); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL rs_addr: got req=%b %h want 1/0080", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rs_flushed: got v=%b %h want 0", inst_valid_o, inst_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1080 || pc_o !== 16'h0080) begin errors++; $display("FAIL rs_target: got v=%b %h pc=%h want 1/1080/0080", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_o !== 16'h1081 || pc_o !== 16'h0081) begin errors++; $display("FAIL rs_next: got %h pc=%h want 1081/0081", inst_o, pc_o); end
    endtask

    task automatic test_gnt_low;
        do_reset(1'b0, 3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL gl_hold%0d: got req=%b %h want 1/0000", k, imem_req, imem_addr); end
            checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL gl_bub%0d: got %b want 0", k, inst_valid_o); end
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL gl_addr1: got req=%b %h want 1/0001", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL gl_limit: got %b want 0", imem_req); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL gl_wait: got %b want 0", inst_valid_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1000 || pc_o !== 16'h0000) begin errors++; $display("FAIL gl_i0: got v=%b %h pc=%h want 1/1000/0000", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1001 || pc_o !== 16'h0001) begin errors++; $display("FAIL gl_i1: got v=%b %h pc=%h want 1/1001/0001", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 16'h0000 || pc_o !== 16'h0001) begin errors++; $display("FAIL gl_bubble: got v=%b %h pc=%h want 0/0000/0001", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL gl_bubble2: got %b want 0", inst_valid_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1002 || pc_o !== 16'h0002) begin errors++; $display("FAIL gl_i2: got v=%b %h pc=%h want 1/1002/0002", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1003 || pc_o !== 16'h0003) begin errors++; $display("FAIL gl_i3: got v=%b %h pc=%h want 1/1003/0003", inst_valid_o, inst_o, pc_o); end
    endtask

    task automatic test_reset_midstream;
        do_reset(1'b1, 1);
        repeat (3) @(negedge clk);
        checks++; if (inst_o !== 16'h1001) begin errors++; $display("FAIL mr_pre: got %h want 1001", inst_o); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 16'h0000) begin errors++; $display("FAIL mr_inst: got v=%b %h want 0/0000", inst_valid_o, inst_o); end
        checks++; if (pc_o !== 16'h0000 || pc_plus1_o !== 16'h0001) begin errors++; $display("FAIL mr_pc: got %h/%h want 0000/0001", pc_o, pc_plus1_o); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL mr_req: got req=%b %h want 0/0000", imem_req, imem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || imem_addr !== 16'h0001) begin errors++; $display("FAIL mr_restart: got v=%b addr=%h want 0/0001", inst_valid_o, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 16'h1000 || pc_o !== 16'h0000) begin errors++; $display("FAIL mr_i0: got v=%b %h pc=%h want 1/1000/0000", inst_valid_o, inst_o, pc_o); end
        @(negedge clk);
        checks++; if (inst_o !== 16'h1001 || pc_o !== 16'h0001) begin errors++; $display("FAIL mr_i1: got %h pc=%h want 1001/0001", inst_o, pc_o); end
    endtask

    initial begin
        test_reset;
        test_fetch_stream;
        test_stall;
        test_redirect;
        test_redirect_stall;
        test_gnt_low;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
